// File: rtl/multiword_add_sequencer.sv
// ============================================================================
// Module   : multiword_add_sequencer (with ripple_carry_adder)
// Brief    : W-bit add/subtract built by time-sharing one 4-bit ripple adder
//            over the operand nibbles, least significant nibble first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_bit
            assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_c[4];
endmodule

module multiword_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 Cin,
    input  logic                 Sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] Sum,
    output logic                 Cout,
    output logic                 Overflow
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_beff;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       w_add_sum;
    logic             w_add_cout;
    logic             w_last;

    assign w_last = (r_idx == C_LAST);

    ripple_carry_adder u_rca (
        .a    (r_a[{r_idx, 2'b00} +: 4]),
        .b    (r_beff[{r_idx, 2'b00} +: 4]),
        .cin  (r_carry),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so only the captured B and carry differ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_beff  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_a     <= A;
            r_beff  <= Sub ? ~B : B;
            r_carry <= Sub ? 1'b1 : Cin;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[{r_idx, 2'b00} +: 4] <= w_add_sum;
            r_carry <= w_add_cout;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            // Top-nibble carry ends here; it never feeds back into nibble 0.
            if (w_last) begin
                r_cout <= w_add_cout;
                r_ovf  <= (r_a[W-1] == r_beff[W-1]) && (w_add_sum[3] != r_a[W-1]);
            end
        end
    end

    assign Sum      = r_sum;
    assign Cout     = r_cout;
    assign Overflow = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_multiword_add_sequencer.sv
// ============================================================================
// Module   : tb_multiword_add_sequencer
// Brief    : Scoreboard bench for multiword_add_sequencer (NIBBLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiword_add_sequencer;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Overflow;

    int   checks     = 0;
    int   failures   = 0;
    int   n_accepts  = 0;
    int   n_results  = 0;
    int   ready_mode = 0;
    logic ready_force = 1'b1;
    exp_t q[$];

    multiword_add_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W-1:0] be;
        logic [W:0]   full;
        exp_t         e;
        be    = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Consumer side: out_ready changes 2 time units after each rising edge.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = (ready_mode != 0) ? ($urandom_range(0, 2) != 0) : ready_force;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_results++;
            if (q.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", 64'(Sum), 64'(e.sum));
                check("cout", 64'(Cout), 64'(e.cout));
                check("overflow", 64'(Overflow), 64'(e.ovf));
            end
        end
    end

    task automatic scramble(input logic iv);
        A        = W'($urandom);
        B        = W'($urandom);
        Cin      = 1'($urandom);
        Sub      = 1'($urandom);
        in_valid = iv;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input exp_t e);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                n_accepts++;
                @(posedge clk);
                #1;
                scramble(1'b0);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    // Counts edges from the accepting edge to the first visible out_valid,
    // wiggling the inputs meanwhile; the operation must not notice.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int j = 0; j < NIBBLES + 6; j++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = j;
                break;
            end
            @(posedge clk);
            #1;
            scramble(1'($urandom));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input exp_t e);
        int lat;
        issue(a, b, cin, sub, e);
        wait_result(lat);
        check("latency", 64'(lat), 64'(NIBBLES));
    endtask

    initial begin
        int lat;
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(Sum), 64'd0);
        check("rst_cout", 64'(Cout), 64'd0);
        check("rst_overflow", 64'(Overflow), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        op(16'h00FF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h0100, cout: 1'b0, ovf: 1'b0});
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0});
        op(16'h7FFF, 16'h0000, 1'b1, 1'b0, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1});
        op(16'h0005, 16'h0007, 1'b1, 1'b1, '{sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0});
        op(16'h8000, 16'h0001, 1'b0, 1'b1, '{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1});

        // Backpressure: result must hold while new requests are offered.
        @(posedge clk);
        #1;
        ready_force = 1'b0;
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, '{sum: 16'h3333, cout: 1'b0, ovf: 1'b0});
        wait_result(lat);
        check("bp_latency", 64'(lat), 64'(NIBBLES));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            scramble(1'b1);
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_sum", 64'(Sum), 64'h3333);
            check("bp_cout", 64'(Cout), 64'd0);
            check("bp_overflow", 64'(Overflow), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ready_force = 1'b1;
        @(negedge clk);
        check("bp_valid_at_release", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("bp_idle_in_ready", 64'(in_ready), 64'd1);
        check("bp_idle_out_valid", 64'(out_valid), 64'd0);
        check("bp_queue_empty", 64'(q.size()), 64'd0);

        // Asynchronous reset in the second RUN cycle.
        issue(16'hAAAA, 16'h1111, 1'b0, 1'b0, '{sum: 16'hBBBB, cout: 1'b0, ovf: 1'b0});
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum", 64'(Sum), 64'd0);
        e = q.pop_back();
        n_accepts--;
        @(posedge clk);
        #1;
        rst = 1'b0;
        op(16'h1234, 16'h4321, 1'b0, 1'b0, '{sum: 16'h5555, cout: 1'b0, ovf: 1'b0});

        ready_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a, b;
            logic cin, sub;
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            op(a, b, cin, sub, model(a, b, cin, sub));
        end

        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 64'(q.size()), 64'd0);
        check("result_count", 64'(n_results), 64'(n_accepts));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
